dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single synchronous data memory between the pipeline MEM stage (CPU port) and an
//  external requester (loader/debug/DMA, EXT port). Sits between the MEM stage's memory-side
//  outputs (access-aligned address, write data, write enable) and the DMEM macro. Sequences each
//  access through a fixed-latency FSM with optional wait states, stalls the pipeline while the
//  CPU waits, and prevents EXT starvation with a bounded CPU-priority streak.
// PARAMETERS
//  WAIT_CYCLES   0   extra ACCESS cycles per access beyond the first (models slow memory)
//  STARVE_LIMIT  4   consecutive CPU grants allowed while EXT pends before EXT is forced
// PORTS
//  i_clk         in   1   clock; single clock domain, rising edge
//  i_rst_n       in   1   reset, asynchronous, active-low
//  i_cpu_req     in   1   MEM stage requests an access; held stable until o_cpu_done
//  i_cpu_wena    in   1   1 = write, 0 = read
//  i_cpu_addr    in   32  access-aligned address from MEM stage
//  i_cpu_wdata   in   32  write data, already lane-merged by MEM stage
//  o_cpu_stall   out  1   freeze IF..MEM; = i_cpu_req & ~o_cpu_done (combinational)
//  o_cpu_done    out  1   1-cycle pulse: CPU access completes this cycle
//  o_cpu_rdata   out  32  read data, valid only with o_cpu_done & ~wena, else 0
//  i_ext_req     in   1   EXT requests an access; held stable until o_ext_done
//  i_ext_wena    in   1   1 = write, 0 = read
//  i_ext_addr    in   32  EXT address
//  i_ext_wdata   in   32  EXT write data
//  o_ext_gnt     out  1   1-cycle pulse in first ACCESS cycle of an EXT access
//  o_ext_done    out  1   1-cycle pulse: EXT access completes this cycle
//  o_ext_rdata   out  32  read data, valid only with o_ext_done & ~wena, else 0
//  o_mem_en      out  1   registered; DMEM access enable
//  o_mem_wena    out  1   registered; DMEM write enable (only ever high with o_mem_en)
//  o_mem_addr    out  32  registered; DMEM address
//  o_mem_wdata   out  32  registered; DMEM write data
//  i_mem_rdata   in   32  DMEM read data, valid the cycle after the last ACCESS cycle
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state IDLE, owner CPU, o_mem_en/o_mem_wena=0, o_mem_addr/
//    o_mem_wdata=0, o_ext_gnt=0, done pulses 0, wait and streak counters 0. Reset mid-access
//    abandons the access; requesters reissue. o_cpu_stall still follows i_cpu_req during reset.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE.
//    IDLE: if any req, pick owner (arbitration below), at edge latch owner's wena/addr/wdata into
//      o_mem_*, set o_mem_en=1, wait counter=0, go ACCESS; else stay, o_mem_en=0.
//    ACCESS: o_mem_en held; counter increments each cycle; when counter==WAIT_CYCLES go RESP and
//      clear o_mem_en/o_mem_wena at that edge. Length = WAIT_CYCLES+1 cycles.
//    RESP: owner's done pulses; rdata = i_mem_rdata for reads, 0 for writes; always -> IDLE
//      (never re-grants in RESP: the completing request is still asserted this cycle).
//  - Latency, WAIT_CYCLES=0: req seen in IDLE cycle N, ACCESS N+1, done N+2; back-to-back
//    accesses every 3 cycles; generally WAIT_CYCLES+3.
//  - Arbitration (IDLE only): CPU wins unless EXT pending and streak==STARVE_LIMIT. Streak +1 on
//    each CPU grant while i_ext_req=1 (saturates at STARVE_LIMIT); cleared on any EXT grant or on
//    any CPU grant with i_ext_req=0. Only EXT pending -> EXT. Simultaneous first requests -> CPU.
//  - Requests are never dropped; a req deasserted before done is a protocol violation (assert in
//    sim). Inputs sampled only in IDLE; changes during ACCESS/RESP have no effect.
//  - o_ext_gnt high exactly in first ACCESS cycle when owner=EXT.
// STRUCTURE
//  - Package dmem_arb_pkg: FSM state encoding (IDLE/ACCESS/RESP), owner encoding (CPU/EXT),
//    counter width function clog2(max(WAIT_CYCLES,STARVE_LIMIT)+1).
//  - One sub-module: dmem_arb_pick (combinational owner select + streak counter register).
//    FSM, wait counter and o_mem_* registers stay in the top.
// TESTING
//  1 Reset: i_rst_n=0 mid-ACCESS -> o_mem_en=0, state IDLE immediately; no done pulse follows.
//  2 CPU read, WAIT=0: req addr 0x100, mem returns 0xDEADBEEF -> mem_en high N+1 only, done+
//    rdata=0xDEADBEEF at N+2, stall high N..N+1, low N+2.
//  3 CPU write, WAIT=2: addr 0x20 data 0x12345678 -> mem_en/wena high 3 cycles, done at N+4,
//    o_cpu_rdata=0.
//  4 Simultaneous CPU+EXT first req -> CPU first, EXT gnt in the ACCESS after CPU RESP.
//  5 Starvation, LIMIT=4: CPU req continuous, EXT held -> 4 CPU accesses, then EXT, streak=0,
//    then CPU again.
//  6 EXT read only, CPU idle -> gnt pulse N+1, done N+2 with rdata, o_cpu_stall stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMEM port arbiter: FSM states, port owner encoding and counter sizing.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  // Smallest width holding max(wait_cycles, starve_limit); never below 1 bit.
  function automatic int cnt_width(input int wait_cycles, input int starve_limit);
    int m;
    int w;
    m = (wait_cycles > starve_limit) ? wait_cycles : starve_limit;
    w = 1;
    while ((1 << w) < (m + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Owner select for the DMEM arbiter: CPU priority with a bounded streak so EXT cannot starve.
// Combinational pick; the streak register advances only on the grant edge.
module dmem_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic ext_req,
  input  logic grant,
  output logic pick_ext
);

  logic [CW-1:0] streak;
  logic          starved;

  assign starved  = (streak == CW'(STARVE_LIMIT));
  assign pick_ext = ext_req & (~cpu_req | starved);

  // Streak counts CPU wins while EXT waits; any EXT win or uncontended CPU win resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant) begin
      if (pick_ext || !ext_req) begin
        streak <= '0;
      end else if (!starved) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous DMEM between the CPU MEM stage and an external port; each access is
// IDLE -> ACCESS (WAIT_CYCLES+1) -> RESP, done after WAIT_CYCLES+3 cycles, CPU stalled until done.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wena,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_stall,
  output logic        o_cpu_done,
  output logic [31:0] o_cpu_rdata,
  input  logic        i_ext_req,
  input  logic        i_ext_wena,
  input  logic [31:0] i_ext_addr,
  input  logic [31:0] i_ext_wdata,
  output logic        o_ext_gnt,
  output logic        o_ext_done,
  output logic [31:0] o_ext_rdata,
  output logic        o_mem_en,
  output logic        o_mem_wena,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = cnt_width(WAIT_CYCLES, STARVE_LIMIT);

  state_t        state;
  owner_t        owner;
  logic [CW-1:0] wait_cnt;
  logic          acc_wena;
  logic          any_req;
  logic          grant;
  logic          pick_ext;
  logic          resp;

  assign any_req = i_cpu_req | i_ext_req;
  assign grant   = (state == ST_IDLE) & any_req;

  dmem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_pick (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .cpu_req  (i_cpu_req),
    .ext_req  (i_ext_req),
    .grant    (grant),
    .pick_ext (pick_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      wait_cnt    <= '0;
      acc_wena    <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_wena  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_ext_gnt   <= 1'b0;
    end else begin
      o_ext_gnt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner       <= pick_ext ? OWN_EXT : OWN_CPU;
            acc_wena    <= pick_ext ? i_ext_wena  : i_cpu_wena;
            o_mem_wena  <= pick_ext ? i_ext_wena  : i_cpu_wena;
            o_mem_addr  <= pick_ext ? i_ext_addr  : i_cpu_addr;
            o_mem_wdata <= pick_ext ? i_ext_wdata : i_cpu_wdata;
            o_mem_en    <= 1'b1;
            o_ext_gnt   <= pick_ext;
            wait_cnt    <= '0;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt == CW'(WAIT_CYCLES)) begin
            o_mem_en   <= 1'b0;
            o_mem_wena <= 1'b0;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // The finishing request is still high here, so never re-grant from RESP.
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign resp        = (state == ST_RESP);
  assign o_cpu_done  = resp & (owner == OWN_CPU);
  assign o_ext_done  = resp & (owner == OWN_EXT);
  assign o_cpu_rdata = (o_cpu_done & ~acc_wena) ? i_mem_rdata : '0;
  assign o_ext_rdata = (o_ext_done & ~acc_wena) ? i_mem_rdata : '0;
  assign o_cpu_stall = i_cpu_req & ~o_cpu_done;

  // A requester must hold its request from grant through its done cycle.
  cpu_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state != ST_IDLE && owner == OWN_CPU) |-> i_cpu_req);
  ext_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state != ST_IDLE && owner == OWN_EXT) |-> i_ext_req);

endmodule
